osc_trig_capture: RTL and testbench
===================================

// Module: osc_trig_capture
// PURPOSE
//  ADC-side capture front end of the scope datapath; drives the write port of the sample wfifo.
//  - Decimates incoming ADC samples and applies edge trigger with hysteresis and auto mode.
//  - After trigger, packs PACK samples per word and writes capture_len words into the FIFO.
//  - Runs in the ADC/FIFO write clock domain. Read side and display are downstream.
// PARAMETERS
//  SAMPLE_W     8       ADC sample width
//  PACK         4       samples per FIFO word (fifo_wr_data width = SAMPLE_W*PACK = 32)
//  LEN_W        16      capture_len width (words)
//  DECIM_W      16      decim width
//  HYST         4       trigger hysteresis, in LSB
//  AUTO_TIMEOUT 100000  kept samples to wait before forced trigger in auto mode
// PORTS
//  clk               in   1                 ADC / FIFO write clock
//  rst_n             in   1                 Reset: asynchronous assert, active-low
//  adc_data          in   SAMPLE_W          ADC sample, unsigned
//  adc_valid         in   1                 sample strobe
//  arm               in   1                 1-cycle pulse; start (or restart) a capture
//  trig_level        in   SAMPLE_W          trigger threshold
//  trig_edge         in   1                 0 = rising, 1 = falling
//  trig_auto         in   1                 1 = auto mode (timeout forces trigger)
//  decim             in   DECIM_W           keep 1 of every decim+1 valid samples
//  capture_len       in   LEN_W             words to capture
//  fifo_wr_en        out  1                 FIFO write strobe
//  fifo_wr_data      out  SAMPLE_W*PACK     packed word; oldest sample in [SAMPLE_W-1:0]
//  fifo_full         in   1                 FIFO wr_full
//  busy              out  1                 high in WAIT_TRIG and CAPTURE
//  done              out  1                 high in DONE, until the next arm
//  overflow          out  1                 sticky; set when a word is dropped; cleared by arm
// BEHAVIOUR
//  - Reset: every output is 0; state is IDLE; counters, armed flag and packer are cleared.
//  - Control inputs are sampled on arm and held for the rest of the capture.
//  - FSM states and transitions:
//      IDLE -arm-> WAIT_TRIG -trig-> CAPTURE -last word-> DONE -arm-> WAIT_TRIG
//      arm in any state returns to WAIT_TRIG:
//        partial word discarded, decimation and timeout counters cleared, overflow cleared.
//      capture_len == 0 on arm: go straight to DONE, write nothing.
//  - Decimation: a counter runs on adc_valid.
//      The sample is kept when the counter is 0; the counter wraps after decim.
//      decim = 0 keeps every sample. The counter restarts at 0 on arm.
//  - Rising trigger (per kept sample):
//      armed flag sets when sample < trig_level - HYST (saturating at 0).
//      Trigger when armed && sample >= trig_level.
//  - Falling trigger (per kept sample):
//      armed flag sets when sample > trig_level + HYST (saturating at max).
//      Trigger when armed && sample <= trig_level.
//  - Auto mode: if AUTO_TIMEOUT kept samples pass in WAIT_TRIG with no trigger,
//      the next kept sample forces the trigger.
//  - The triggering sample is sample 0 of word 0.
//  - Packing: each kept sample in CAPTURE fills the next slot.
//      fifo_wr_en is registered: a 1-cycle pulse in the cycle after the edge
//      at which the PACK-th sample of a word is kept.
//  - fifo_full high when a word completes: the word is dropped (no wr_en) and overflow is set.
//      The word still counts toward capture_len. No stall and no retry.
//  - The last word is counted on the same edge as its wr_en is registered;
//      the FSM enters DONE on that edge.
//  - adc_valid is ignored in IDLE and DONE.
// STRUCTURE
//  - Shared package osc_pkg: FSM state encoding localparams (IDLE/WAIT_TRIG/CAPTURE/DONE)
//    and the SAMPLE_W/PACK defaults shared with the wfifo instance.
//  - Sub-module osc_trig_detect: decimation strobe, armed flag with hysteresis, auto timeout;
//    outputs keep and trig.
//  - Top level: FSM, packer, word counter, overflow.
// TESTING
//  1. decim=0, level=128, rising, len=2, ramp 0..255 one per cycle
//     -> words 0x83828180 then 0x87868584, exactly 2 wr_en pulses, done=1.
//  2. Falling edge, level=100, input toggles 98/102
//     -> no trigger (never > 104). After one sample 110, the next 98 triggers.
//  3. decim=3, ramp 0..255 -> captured samples step by 4 (e.g. 0x8C888480).
//  4. Constant 0x10 input:
//     auto=1 -> trigger on kept sample AUTO_TIMEOUT+1, words 0x10101010.
//     auto=0 -> stays in WAIT_TRIG.
//  5. fifo_full held during word 1 of len=3
//     -> 2 writes, overflow=1, done after 3 word times.
//  6. arm after 2 samples of CAPTURE -> no partial write, overflow cleared, back in WAIT_TRIG.
//     rst_n low mid-capture -> all outputs 0 immediately.

Source files
------------

// File: rtl/osc_pkg.sv
// Shared scope-datapath definitions: capture FSM encoding and the sample/packing
// defaults that the wfifo instance is sized from.
package osc_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_TRIG = 2'd1;
  localparam logic [1:0] ST_CAPTURE   = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  localparam int SAMPLE_W_DEF = 8;
  localparam int PACK_DEF     = 4;

endpackage

// File: rtl/osc_trig_detect.sv
// Decimation strobe, hysteresis-armed edge trigger and auto-mode timeout
// for the capture front end. keep/trig are combinational on the current sample.
module osc_trig_detect
  import osc_pkg::*;
#(
  parameter int SAMPLE_W     = SAMPLE_W_DEF,
  parameter int DECIM_W      = 16,
  parameter int HYST         = 4,
  parameter int AUTO_TIMEOUT = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                active,
  input  logic                waiting,
  input  logic                adc_valid,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic [SAMPLE_W-1:0] level,
  input  logic                fall,
  input  logic                auto_en,
  input  logic [DECIM_W-1:0]  decim,
  output logic                keep,
  output logic                trig
);

  localparam int TO_W = (AUTO_TIMEOUT > 0) ? $clog2(AUTO_TIMEOUT + 1) : 1;
  localparam logic [SAMPLE_W-1:0] S_HYST = SAMPLE_W'(HYST);
  localparam logic [SAMPLE_W-1:0] S_MAX  = {SAMPLE_W{1'b1}};
  localparam logic [TO_W-1:0]     TO_LIM = TO_W'(AUTO_TIMEOUT);

  logic [DECIM_W-1:0]  dec_cnt_r;
  logic                armed_r;
  logic [TO_W-1:0]     to_cnt_r;
  logic [SAMPLE_W-1:0] thr_lo_s;
  logic [SAMPLE_W-1:0] thr_hi_s;
  logic                hit_s;
  logic                arm_cond_s;
  logic                timed_out_s;

  assign keep        = active & adc_valid & (dec_cnt_r == {DECIM_W{1'b0}});
  assign timed_out_s = auto_en & (to_cnt_r == TO_LIM);
  assign trig        = keep & waiting & ((armed_r & hit_s) | timed_out_s);

  // Hysteresis thresholds saturate at the sample range ends, then edge-select compares.
  always_comb begin
    thr_lo_s   = {SAMPLE_W{1'b0}};
    thr_hi_s   = S_MAX;
    hit_s      = 1'b0;
    arm_cond_s = 1'b0;
    if (level >= S_HYST) begin
      thr_lo_s = level - S_HYST;
    end else begin
      thr_lo_s = {SAMPLE_W{1'b0}};
    end
    if (level <= (S_MAX - S_HYST)) begin
      thr_hi_s = level + S_HYST;
    end else begin
      thr_hi_s = S_MAX;
    end
    if (fall) begin
      hit_s      = (adc_data <= level);
      arm_cond_s = (adc_data > thr_hi_s);
    end else begin
      hit_s      = (adc_data >= level);
      arm_cond_s = (adc_data < thr_lo_s);
    end
  end

  // Decimation counter: sample kept at 0, wraps after decim.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt_r <= {DECIM_W{1'b0}};
    end else if (clear) begin
      dec_cnt_r <= {DECIM_W{1'b0}};
    end else if (active && adc_valid) begin
      if (dec_cnt_r == decim) begin
        dec_cnt_r <= {DECIM_W{1'b0}};
      end else begin
        dec_cnt_r <= dec_cnt_r + DECIM_W'(1);
      end
    end
  end

  // Armed flag and saturating auto timeout, both only advance while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_r  <= 1'b0;
      to_cnt_r <= {TO_W{1'b0}};
    end else if (clear) begin
      armed_r  <= 1'b0;
      to_cnt_r <= {TO_W{1'b0}};
    end else if (keep && waiting) begin
      if (arm_cond_s) begin
        armed_r <= 1'b1;
      end
      if (!trig && (to_cnt_r != TO_LIM)) begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end
    end
  end

endmodule

// File: rtl/osc_trig_capture.sv
// ADC-side capture front end: FSM, sample packer, word counter and overflow flag
// driving the write port of the sample wfifo.
module osc_trig_capture
  import osc_pkg::*;
#(
  parameter int SAMPLE_W     = SAMPLE_W_DEF,
  parameter int PACK         = PACK_DEF,
  parameter int LEN_W        = 16,
  parameter int DECIM_W      = 16,
  parameter int HYST         = 4,
  parameter int AUTO_TIMEOUT = 100000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SAMPLE_W-1:0]      adc_data,
  input  logic                     adc_valid,
  input  logic                     arm,
  input  logic [SAMPLE_W-1:0]      trig_level,
  input  logic                     trig_edge,
  input  logic                     trig_auto,
  input  logic [DECIM_W-1:0]       decim,
  input  logic [LEN_W-1:0]         capture_len,
  output logic                     fifo_wr_en,
  output logic [SAMPLE_W*PACK-1:0] fifo_wr_data,
  input  logic                     fifo_full,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int WORD_W = SAMPLE_W * PACK;
  localparam int SLOT_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PACK - 1);

  logic [1:0]          state_r, state_nxt_s;
  logic [SAMPLE_W-1:0] level_r;
  logic                fall_r, auto_r;
  logic [DECIM_W-1:0]  decim_r;
  logic [LEN_W-1:0]    len_r, word_cnt_r;
  logic [SLOT_W-1:0]   slot_r;
  logic [WORD_W-1:0]   pack_r, word_s, wr_data_r;
  logic                wr_en_r, busy_r, done_r, overflow_r;
  logic                active_s, waiting_s, keep_s, trig_s, capt_s;
  logic                last_slot_s, last_word_s;

  // The arm cycle itself never consumes a sample: controls are not latched yet.
  assign active_s    = ((state_r == ST_WAIT_TRIG) || (state_r == ST_CAPTURE)) & ~arm;
  assign waiting_s   = (state_r == ST_WAIT_TRIG) & ~arm;
  assign capt_s      = trig_s | (keep_s & (state_r == ST_CAPTURE));
  assign last_slot_s = (slot_r == LAST_SLOT);
  assign last_word_s = (word_cnt_r == (len_r - LEN_W'(1)));

  osc_trig_detect #(
    .SAMPLE_W    (SAMPLE_W),
    .DECIM_W     (DECIM_W),
    .HYST        (HYST),
    .AUTO_TIMEOUT(AUTO_TIMEOUT)
  ) u_detect (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (arm),
    .active   (active_s),
    .waiting  (waiting_s),
    .adc_valid(adc_valid),
    .adc_data (adc_data),
    .level    (level_r),
    .fall     (fall_r),
    .auto_en  (auto_r),
    .decim    (decim_r),
    .keep     (keep_s),
    .trig     (trig_s)
  );

  // Next state: arm overrides everything; last word completion wins over trigger.
  always_comb begin
    state_nxt_s = state_r;
    if (arm) begin
      if (capture_len == {LEN_W{1'b0}}) begin
        state_nxt_s = ST_DONE;
      end else begin
        state_nxt_s = ST_WAIT_TRIG;
      end
    end else if (capt_s && last_slot_s && last_word_s) begin
      state_nxt_s = ST_DONE;
    end else if (trig_s) begin
      state_nxt_s = ST_CAPTURE;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Completed word: earlier slots from the packer, newest sample on top.
  always_comb begin
    word_s = pack_r;
    word_s[WORD_W-1 -: SAMPLE_W] = adc_data;
  end

  // State register with status flags decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_WAIT_TRIG) || (state_nxt_s == ST_CAPTURE);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Capture controls are frozen at arm for the whole capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= {SAMPLE_W{1'b0}};
      fall_r  <= 1'b0;
      auto_r  <= 1'b0;
      decim_r <= {DECIM_W{1'b0}};
      len_r   <= {LEN_W{1'b0}};
    end else if (arm) begin
      level_r <= trig_level;
      fall_r  <= trig_edge;
      auto_r  <= trig_auto;
      decim_r <= decim;
      len_r   <= capture_len;
    end
  end

  // Packer, word counter and FIFO write; a full FIFO drops the word but still counts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_r     <= {SLOT_W{1'b0}};
      word_cnt_r <= {LEN_W{1'b0}};
      pack_r     <= {WORD_W{1'b0}};
      wr_en_r    <= 1'b0;
      wr_data_r  <= {WORD_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      wr_en_r <= 1'b0;
      if (arm) begin
        slot_r     <= {SLOT_W{1'b0}};
        word_cnt_r <= {LEN_W{1'b0}};
        pack_r     <= {WORD_W{1'b0}};
        overflow_r <= 1'b0;
      end else if (capt_s) begin
        for (int i = 0; i < PACK; i++) begin
          if (slot_r == SLOT_W'(i)) begin
            pack_r[i*SAMPLE_W +: SAMPLE_W] <= adc_data;
          end
        end
        if (last_slot_s) begin
          slot_r     <= {SLOT_W{1'b0}};
          word_cnt_r <= word_cnt_r + LEN_W'(1);
          if (fifo_full) begin
            overflow_r <= 1'b1;
          end else begin
            wr_en_r   <= 1'b1;
            wr_data_r <= word_s;
          end
        end else begin
          slot_r <= slot_r + SLOT_W'(1);
        end
      end
    end
  end

  assign fifo_wr_en   = wr_en_r;
  assign fifo_wr_data = wr_data_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_osc_trig_capture.sv
// Directed bench for osc_trig_capture: a table of capture scenarios plus
// hand-written sequences for falling hysteresis, FIFO full, re-arm and reset.
module tb_osc_trig_capture;

  localparam int SW = 8;
  localparam int PK = 4;
  localparam int LW = 16;
  localparam int DW = 16;
  localparam int TO = 20;
  localparam int NV = 9;
  localparam int NCYC = 400;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] adc_data;
  logic          adc_valid;
  logic          arm;
  logic [SW-1:0] trig_level;
  logic          trig_edge;
  logic          trig_auto;
  logic [DW-1:0] decim;
  logic [LW-1:0] capture_len;
  logic          fifo_wr_en;
  logic [31:0]   fifo_wr_data;
  logic          fifo_full;
  logic          busy;
  logic          done;
  logic          overflow;

  osc_trig_capture #(
    .SAMPLE_W(SW), .PACK(PK), .LEN_W(LW), .DECIM_W(DW), .HYST(4), .AUTO_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid), .arm(arm),
    .trig_level(trig_level), .trig_edge(trig_edge), .trig_auto(trig_auto), .decim(decim),
    .capture_len(capture_len), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_full(fifo_full), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] decim;
    logic [7:0]  level;
    logic        fall;
    logic        auto_m;
    logic [15:0] len;
    logic        ramp;
    logic [7:0]  start;
    int          exp_n;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
    int          exp_first;
    logic        exp_done;
  } vec_t;

  vec_t        vt[NV];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] wq[$];
  int          first_k;
  int          done_k;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_arm(input logic [15:0] dc, input logic [7:0] lv, input logic fl,
                        input logic au, input logic [15:0] ln);
    decim = dc; trig_level = lv; trig_edge = fl; trig_auto = au; capture_len = ln;
    arm = 1'b1; adc_valid = 1'b0; fifo_full = 1'b0;
    @(posedge clk); #1;
    arm = 1'b0;
    wq.delete();
    first_k = -1;
    done_k = -1;
  endtask

  task automatic step(input int k, input logic [7:0] d, input logic full);
    adc_data = d; adc_valid = 1'b1; fifo_full = full;
    @(posedge clk); #1;
    if (fifo_wr_en) begin
      wq.push_back(fifo_wr_data);
      if (first_k < 0) first_k = k;
    end
    if (done && done_k < 0) done_k = k;
  endtask

  function automatic logic [31:0] wq_at(input int i);
    if (i < wq.size()) return wq[i];
    return 32'hDEADBEEF;
  endfunction

  initial begin
    //        decim  lvl    fall  auto  len    ramp  start  n  w0            w1            first done
    vt[0] = '{16'd0, 8'd128, 1'b0, 1'b0, 16'd2, 1'b1, 8'h00, 2, 32'h83828180, 32'h87868584, 131, 1'b1};
    vt[1] = '{16'd3, 8'd128, 1'b0, 1'b0, 16'd2, 1'b1, 8'h00, 2, 32'h8C888480, 32'h9C989490, 140, 1'b1};
    vt[2] = '{16'd1, 8'd128, 1'b0, 1'b0, 16'd1, 1'b1, 8'h00, 1, 32'h86848280, 32'h0,        134, 1'b1};
    vt[3] = '{16'd0, 8'd128, 1'b0, 1'b1, 16'd1, 1'b0, 8'h10, 1, 32'h10101010, 32'h0,        23,  1'b1};
    vt[4] = '{16'd0, 8'd128, 1'b0, 1'b0, 16'd1, 1'b0, 8'h10, 0, 32'h0,        32'h0,        -1,  1'b0};
    vt[5] = '{16'd0, 8'd128, 1'b1, 1'b0, 16'd1, 1'b1, 8'h00, 1, 32'h03020100, 32'h0,        259, 1'b1};
    vt[6] = '{16'd0, 8'd2,   1'b0, 1'b0, 16'd1, 1'b1, 8'h00, 0, 32'h0,        32'h0,        -1,  1'b0};
    vt[7] = '{16'd0, 8'd253, 1'b1, 1'b0, 16'd1, 1'b1, 8'h00, 0, 32'h0,        32'h0,        -1,  1'b0};
    vt[8] = '{16'd0, 8'd128, 1'b0, 1'b0, 16'd0, 1'b1, 8'h00, 0, 32'h0,        32'h0,        -1,  1'b1};

    rst_n = 1'b0; arm = 1'b0; adc_valid = 1'b0; adc_data = 8'h00; fifo_full = 1'b0;
    trig_level = 8'h00; trig_edge = 1'b0; trig_auto = 1'b0; decim = 16'd0; capture_len = 16'd0;
    first_k = -1; done_k = -1;
    repeat (3) @(posedge clk);
    #1;
    check("rst wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst wr_data", fifo_wr_data, 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      do_arm(vt[i].decim, vt[i].level, vt[i].fall, vt[i].auto_m, vt[i].len);
      for (int k = 0; k < NCYC; k++) begin
        step(k, vt[i].ramp ? 8'(vt[i].start + k) : vt[i].start, 1'b0);
      end
      check($sformatf("v%0d n_wr", i), 32'(wq.size()), 32'(vt[i].exp_n));
      if (vt[i].exp_n > 0) check($sformatf("v%0d word0", i), wq_at(0), vt[i].exp_w0);
      if (vt[i].exp_n > 1) check($sformatf("v%0d word1", i), wq_at(1), vt[i].exp_w1);
      check($sformatf("v%0d first_wr", i), 32'(first_k), 32'(vt[i].exp_first));
      check($sformatf("v%0d done", i), 32'(done), 32'(vt[i].exp_done));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(!vt[i].exp_done));
      check($sformatf("v%0d overflow", i), 32'(overflow), 32'd0);
    end

    // Falling edge, level 100: 98/102 toggling never exceeds 104.
    do_arm(16'd0, 8'd100, 1'b1, 1'b0, 16'd1);
    for (int k = 0; k < 20; k++) step(k, (k % 2 == 1) ? 8'd102 : 8'd98, 1'b0);
    check("fall toggle n_wr", 32'(wq.size()), 32'd0);
    check("fall toggle busy", 32'(busy), 32'd1);
    step(20, 8'd110, 1'b0);
    for (int k = 21; k < 30; k++) step(k, 8'(77 + k), 1'b0);
    check("fall n_wr", 32'(wq.size()), 32'd1);
    check("fall word", wq_at(0), 32'h65646362);
    check("fall first_wr", 32'(first_k), 32'd24);
    check("fall done", 32'(done), 32'd1);

    // FIFO full while word 1 of 3 completes.
    do_arm(16'd0, 8'd128, 1'b0, 1'b0, 16'd3);
    for (int k = 0; k < 160; k++) step(k, 8'(k), (k >= 132) && (k <= 135));
    check("full n_wr", 32'(wq.size()), 32'd2);
    check("full word0", wq_at(0), 32'h83828180);
    check("full word2", wq_at(1), 32'h8B8A8988);
    check("full overflow", 32'(overflow), 32'd1);
    check("full done_k", 32'(done_k), 32'd139);

    // Re-arm two samples into word 1 after word 0 was dropped.
    do_arm(16'd0, 8'd128, 1'b0, 1'b0, 16'd3);
    for (int k = 0; k < 134; k++) step(k, 8'(k), 1'b1);
    check("rearm pre overflow", 32'(overflow), 32'd1);
    arm = 1'b1; adc_data = 8'd134; adc_valid = 1'b1; fifo_full = 1'b0;
    @(posedge clk); #1;
    arm = 1'b0;
    check("rearm overflow", 32'(overflow), 32'd0);
    check("rearm busy", 32'(busy), 32'd1);
    check("rearm wr_en", 32'(fifo_wr_en), 32'd0);
    for (int k = 0; k < 30; k++) step(k, 8'h10, 1'b0);
    check("rearm n_wr", 32'(wq.size()), 32'd0);
    check("rearm waiting", 32'(busy & ~done), 32'd1);
    for (int k = 30; k < 34; k++) step(k, 8'(170 + k), 1'b0);
    check("rearm new word", wq_at(0), 32'hCBCAC9C8);
    check("rearm first_wr", 32'(first_k), 32'd33);

    // Asynchronous reset in the middle of a capture.
    do_arm(16'd0, 8'd128, 1'b0, 1'b0, 16'd2);
    for (int k = 0; k < 130; k++) step(k, 8'(k), 1'b0);
    check("pre-reset busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst wr_en", 32'(fifo_wr_en), 32'd0);
    check("async rst wr_data", fifo_wr_data, 32'd0);
    check("async rst overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
